ifir_tdm_sequencer: RTL
=======================

# ifir_tdm_sequencer

Time-multiplexed controller and datapath for the first IFIR interpolation stage (2x upsampling, 24 symmetric taps plus a center-tap phase). It replaces 24 parallel constant multipliers with one shared pre-add/multiply/accumulate unit that it sequences over 12 cycles per input sample. The block sits between the sample source and the second IFIR stage and uses a valid/ready handshake on both sides. It is bit-exact with the team's fully parallel first stage.

## Interface
- COEF_W, 24: signed coefficient width. The coefficient ROM c[0..11] = 32, 65, 520, 1024, 8260, 4369, 32776, 73746, 133252, 270594, 2170882, 4457490 is internal. The center-tap coefficient is 2^24.
- ACC_W, 38: accumulator width. Arithmetic wraps modulo 2^ACC_W.

Ports:
- clock_up  in  1  single clock; all state is sampled on the rising edge
- rstn  in  1  asynchronous, active-low reset
- in_data  in  24  signed input sample x[n]
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample; high only in IDLE
- flush  in  1  one-cycle request to zero the delay-line history
- out_data  out  24  signed output sample
- out_phase  out  1  0 = symmetric-sum phase, 1 = center-tap phase
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts the output
- busy  out  1  high in every state except IDLE

## Operation
- The delay line is a 24-entry circular buffer of 24-bit signed samples with a 5-bit write pointer wr_ptr that wraps 23→0.
  - On accept, x[n] is written at wr_ptr and wr_ptr advances.
  - Read addresses are computed modulo 24 relative to the newest sample.
- States:
  - IDLE → MAC on accept (in_valid & in_ready).
  - IDLE → FLUSH when flush is pending.
  - MAC (i = 0..11) → OUT0 after i = 11.
  - OUT0 → OUT1 on out_ready.
  - OUT1 → IDLE on out_ready.
  - FLUSH (24 cycles) → IDLE.
- MAC step i:
  - pre = x[n-i] + x[n-23+i], 25-bit signed.
  - prod = pre * c[i].
  - acc = (i == 0 ? 0 : acc) + prod, truncated to ACC_W.
- Phase-1 value: (x[n-11] * 2^24) truncated to ACC_W.
- Output in both phases: out_data = acc[35:12]. No rounding, no saturation.
- OUT0: out_valid = 1, out_phase = 0, result of the symmetric sum. Holds until out_ready.
- OUT1: out_valid = 1, out_phase = 1, center-tap result. Holds until out_ready.
- FLUSH:
  - Writes zero to one buffer entry per cycle for 24 cycles, then sets wr_ptr = 0.
  - in_ready = 0 during FLUSH.
- Flush requests:
  - A flush pulse outside IDLE is latched in flush_pend.
  - The flush executes on the next entry to IDLE, before any new sample is accepted.
  - In IDLE, a flush in the same cycle as in_valid takes priority: the sample is not accepted (in_ready is driven low that cycle).
- The history at stream start is all zeros after reset or flush.

## Timing
- Reset values:
  - State IDLE, buffer and pointer all zero, acc = 0, flush_pend = 0.
  - Outputs: in_ready = 1, out_valid = 0, out_phase = 0, out_data = 0, busy = 0.
- rstn low mid-operation aborts immediately to the reset values. The partial result is discarded and never presented.
- Accept occurs at edge 0. MAC runs on edges 1..12. out_valid (phase 0) rises after edge 12 and is visible in cycle 13.
- With out_ready held high:
  - phase 0 is transferred at edge 13, phase 1 at edge 14;
  - in_ready is high again in cycle 15;
  - minimum period is 15 clocks per input sample.
- out_data, out_phase and out_valid are registered and stable while out_valid = 1 and out_ready = 0.
- A flush takes 24 clocks. in_ready returns high in the cycle after the 24th write.

## Test plan
- Impulse of 4096 followed by 23 zeros → phase-0 outputs are 32, 65, 520, 1024, 8260, 4369, 32776, 73746, 133252, 270594, 2170882, 4457490, then the mirror sequence 4457490 ... 32. Phase 1 is 0 on every sample.
- Impulse of 1 followed by zeros → the phase-1 output for the 12th sample (x[n-11] = 1) is 4096; every other phase-1 output is 0. Phase-0 outputs are c[i]>>12, i.e. 0, 0, 0, 0, 2, 1, 8, 18, 32, 66, 530, 1088, then the mirror sequence.
- DC input of -8388608 for 40 samples with random out_ready stalls:
  - every result matches the bit-exact model, including 38-bit wrap;
  - out_data is stable while stalled;
  - no sample is lost or duplicated.
- flush asserted during MAC after a nonzero history → the current sample completes both phases, then 24 FLUSH cycles run with in_ready = 0. The next impulse of 4096 reproduces the exact first-scenario sequence.
- rstn pulled low during MAC step 6 → out_valid stays 0, all outputs return to reset values, and the next stream matches a fresh-reset reference.
- 60 random samples with in_valid gaps, covering multiple wr_ptr wraps 23→0 → outputs match the reference model, in phase order 0, 1.

Source files
------------

// File: rtl/ifir_tdm_sequencer.sv
// ifir_tdm_sequencer
// First IFIR interpolation stage (2x) built around one shared pre-add /
// multiply / accumulate unit. Each accepted sample runs 12 MAC steps over a
// 24-entry circular delay line. The stage then presents two results: the
// symmetric-sum phase and the center-tap phase. Arithmetic wraps modulo 2^ACC_W.
module ifir_tdm_sequencer #(
    parameter int COEF_W = 24,
    parameter int ACC_W  = 38
) (
    input  logic        clock_up,
    input  logic        rstn,
    input  logic [23:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [23:0] out_data,
    output logic        out_phase,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam int DATA_W = 24;
    localparam int TAPS   = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_OUT0  = 3'd2,
        ST_OUT1  = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    // Half of the symmetric coefficient set; tap i and tap 23-i share c[i].
    function automatic logic signed [COEF_W-1:0] coef_rom(input logic [3:0] idx);
        logic signed [COEF_W-1:0] c;
        case (idx)
            4'd0:    c = 24'sd32;
            4'd1:    c = 24'sd65;
            4'd2:    c = 24'sd520;
            4'd3:    c = 24'sd1024;
            4'd4:    c = 24'sd8260;
            4'd5:    c = 24'sd4369;
            4'd6:    c = 24'sd32776;
            4'd7:    c = 24'sd73746;
            4'd8:    c = 24'sd133252;
            4'd9:    c = 24'sd270594;
            4'd10:   c = 24'sd2170882;
            4'd11:   c = 24'sd4457490;
            default: c = 24'sd0;
        endcase
        return c;
    endfunction

    // Reduce a value below 48 into the 0..23 delay-line address range.
    function automatic logic [4:0] mod24(input logic [5:0] v);
        logic [5:0] r;
        if (v >= 6'd24) begin
            r = v - 6'd24;
        end else begin
            r = v;
        end
        return r[4:0];
    endfunction

    state_t                   state_q,      state_d;
    logic [4:0]               cnt_q,        cnt_d;
    logic [4:0]               wr_ptr_q,     wr_ptr_d;
    logic [ACC_W-1:0]         acc_q,        acc_d;
    logic                     flush_pend_q, flush_pend_d;
    logic [DATA_W-1:0]        out_data_q,   out_data_d;
    logic                     out_phase_q,  out_phase_d;
    logic                     out_valid_q,  out_valid_d;
    logic [DATA_W-1:0]        dline_q [TAPS];
    logic [DATA_W-1:0]        dline_d [TAPS];

    logic [4:0]               newest_s;
    logic [4:0]               addr_a_s;
    logic [4:0]               addr_b_s;
    logic [4:0]               addr_c_s;
    logic [DATA_W-1:0]        x_a_s;
    logic [DATA_W-1:0]        x_b_s;
    logic [DATA_W-1:0]        x_c_s;
    logic signed [DATA_W:0]   pre_s;
    logic signed [COEF_W-1:0] coef_s;
    logic signed [ACC_W-1:0]  prod_s;
    logic [ACC_W-1:0]         center_s;
    logic                     in_ready_s;

    // Delay-line read addressing and the shared pre-add / multiply datapath.
    always_comb begin
        // wr_ptr has already advanced past the newest sample during MAC/OUT.
        if (wr_ptr_q == 5'd0) begin
            newest_s = 5'd23;
        end else begin
            newest_s = wr_ptr_q - 5'd1;
        end
        // x[n-i], x[n-23+i] and x[n-11], all taken modulo 24.
        addr_a_s = mod24({1'b0, newest_s} + 6'd24 - {2'b00, cnt_q[3:0]});
        addr_b_s = mod24({1'b0, newest_s} + 6'd1 + {2'b00, cnt_q[3:0]});
        addr_c_s = mod24({1'b0, newest_s} + 6'd13);
        x_a_s    = dline_q[addr_a_s];
        x_b_s    = dline_q[addr_b_s];
        x_c_s    = dline_q[addr_c_s];
        pre_s    = $signed({x_a_s[DATA_W-1], x_a_s}) + $signed({x_b_s[DATA_W-1], x_b_s});
        coef_s   = coef_rom(cnt_q[3:0]);
        // Only the low ACC_W bits of the product matter because the sum wraps.
        prod_s   = ACC_W'(pre_s) * ACC_W'(coef_s);
        // Center tap is x[n-11] * 2^24, sign-extended before the shift.
        center_s = {{(ACC_W-DATA_W){x_c_s[DATA_W-1]}}, x_c_s} << 24;
    end

    // Sequencer next-state logic: accept, MAC steps, two output phases, flush.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_ptr_d     = wr_ptr_q;
        acc_d        = acc_q;
        flush_pend_d = flush_pend_q;
        out_data_d   = out_data_q;
        out_phase_d  = out_phase_q;
        out_valid_d  = out_valid_q;
        dline_d      = dline_q;
        // A flush in the same cycle as a sample wins, so the sample is refused.
        in_ready_s   = (state_q == ST_IDLE) && !flush && !flush_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (flush || flush_pend_q) begin
                    state_d      = ST_FLUSH;
                    cnt_d        = 5'd0;
                    flush_pend_d = 1'b0;
                end else if (in_valid) begin
                    dline_d[wr_ptr_q] = in_data;
                    if (wr_ptr_q == 5'd23) begin
                        wr_ptr_d = 5'd0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 5'd1;
                    end
                    state_d = ST_MAC;
                    cnt_d   = 5'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (cnt_q == 5'd0) begin
                    acc_d = ACC_W'(prod_s);
                end else begin
                    acc_d = acc_q + ACC_W'(prod_s);
                end
                if (cnt_q == 5'd11) begin
                    state_d     = ST_OUT0;
                    cnt_d       = 5'd0;
                    out_valid_d = 1'b1;
                    out_phase_d = 1'b0;
                    out_data_d  = acc_d[35:12];
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_OUT0: begin
                if (out_ready) begin
                    state_d     = ST_OUT1;
                    acc_d       = center_s;
                    out_phase_d = 1'b1;
                    out_data_d  = center_s[35:12];
                end else begin
                    state_d = ST_OUT0;
                end
            end
            ST_OUT1: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_phase_d = 1'b0;
                end else begin
                    state_d = ST_OUT1;
                end
            end
            ST_FLUSH: begin
                dline_d[cnt_q] = '0;
                if (cnt_q == 5'd23) begin
                    state_d  = ST_IDLE;
                    cnt_d    = 5'd0;
                    wr_ptr_d = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
            end
        endcase

        // Flush requests outside IDLE wait until the sequencer returns to IDLE.
        if (flush && (state_q != ST_IDLE)) begin
            flush_pend_d = 1'b1;
        end else begin
            flush_pend_d = flush_pend_d;
        end
    end

    // State, datapath and delay-line registers with asynchronous reset.
    always_ff @(posedge clock_up or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 5'd0;
            wr_ptr_q     <= 5'd0;
            acc_q        <= '0;
            flush_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_phase_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                dline_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            acc_q        <= acc_d;
            flush_pend_q <= flush_pend_d;
            out_data_q   <= out_data_d;
            out_phase_q  <= out_phase_d;
            out_valid_q  <= out_valid_d;
            for (int k = 0; k < TAPS; k++) begin
                dline_q[k] <= dline_d[k];
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_q;
    assign out_phase = out_phase_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
